disp_scan_ctrl: RTL
===================

Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for the chronometer's multi-digit seven-segment display.
- Shares one combinational hex-to-seven-segment decoder among NUM_DIGITS digits. Each scan slot it:
  - presents one digit's 4-bit code to the decoder,
  - receives the decoder's 8-bit active-low segment pattern,
  - applies decimal-point, leading-zero and anti-ghosting blanking,
  - drives the active-low anode enables.
- Digit values are snapshotted once per frame so a display never shows a torn count.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; must be ≥2.
- TICK_DIV, 50000, clock cycles per digit slot; must be ≥2.
- BLANK_CYC, 100, dead cycles at the start of each slot with all anodes off; 1 ≤ BLANK_CYC < TICK_DIV.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  display enable; 0 turns the display dark and holds the scan.
- digits_in  in  4*NUM_DIGITS  packed hex digits; [3:0] is digit 0, the least significant and rightmost.
- dp_in  in  NUM_DIGITS  decimal-point request per digit; 1 lights the point.
- blank_lz  in  1  leading-zero blanking enable.
- dec_code  out  4  digit code sent to the shared decoder.
- seg_in  in  8  decoder output; bits [7:1] are segments a..g and bit [0] is dp, all active-low.
- seg  out  8  segment drive to the pins, active-low, same bit order as seg_in.
- an  out  NUM_DIGITS  anode enables, active-low.
- frame_start  out  1  one-cycle pulse on the first cycle of each scan frame.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - cnt=0, idx=0, snapshot registers cleared.
  - an=all 1s, seg=8'hFF, dec_code=0, frame_start=0.
- Slot counter cnt:
  - Width $clog2(TICK_DIV), counts 0..TICK_DIV-1.
  - On wrap, idx increments; idx wraps from NUM_DIGITS-1 to 0.
- Frame start: the cycle with en=1, cnt=0 and idx=0. On that cycle:
  - digits_in, dp_in and blank_lz are captured into snapshot registers,
  - frame_start=1.
  - digits_in changes at any other time have no visible effect until the next frame start.
- Leading-zero mask (computed from the snapshot):
  - With snapshot blank_lz=1, digit i is blanked when every digit from NUM_DIGITS-1 down to i is 0.
  - Digit 0 is never blanked.
  - With blank_lz=0, no digit is blanked.
- Phases within a slot:
  - BLANK, cnt < BLANK_CYC: an=all 1s, seg=8'hFF.
  - SHOW, cnt ≥ BLANK_CYC, digit not blanked: an has only bit idx low; seg={seg_in[7:1], ~dp_snap[idx]}.
  - SHOW, digit blanked: an=all 1s, seg=8'hFF.
- dec_code = snapshot digit idx during the whole slot, and 0 while en=0. This gives the decoder BLANK_CYC cycles to settle before the anode turns on.
- Timing of outputs:
  - an, dec_code and frame_start are decoded from registered state.
  - seg is a combinational mask of seg_in gated by registered state; there is no extra latency through this block.
- Disable and resume:
  - en=0: cnt and idx are forced to 0 each cycle; an=all 1s, seg=8'hFF, frame_start=0.
  - When en rises, the next cycle is a frame start.
- Reset mid-scan: takes effect on the next edge regardless of phase. The display goes dark immediately and the scan restarts at digit 0 with a fresh snapshot once en=1.
- Simultaneous events: rst has priority over en; en=0 has priority over cnt/idx advance.

Test Plan:
All scenarios use NUM_DIGITS=4, TICK_DIV=8, BLANK_CYC=2, with a real hex decoder attached.

1. Reset: hold rst for 3 cycles with en=1.
   -> an=4'hF, seg=8'hFF, dec_code=0, frame_start=0.
   -> First cycle after release: frame_start=1.
2. Scan order: digits_in=16'h1234, dp_in=0, blank_lz=0, en=1.
   -> Slot 0: dec_code=4; cycles 0-1 an=4'hF; cycles 2-7 an=4'b1110, seg=8'b10011001.
   -> Then slots show 3, 2, 1 on an=1101, 1011, 0111.
   -> frame_start every 32 cycles.
3. Decimal point: dp_in=4'b0010, digits 16'h1234.
   -> Slot 1: seg=8'b00001100 (digit 3 with dp low); other slots have bit0=1.
4. Leading zeros, blank_lz=1:
   -> digits 16'h0050: slots 3 and 2 have an=4'hF and seg=8'hFF; slot 1 shows 5 (8'b01001001); slot 0 shows 0 (8'b00000011).
   -> digits 16'h0000: only slot 0 lit, showing 0.
5. Tear-free update: change digits_in from 16'h1234 to 16'h5678 during slot 1.
   -> Slots 2 and 3 still show 2 and 1.
   -> Next frame shows 8, 7, 6, 5.
6. Disable and mid-scan reset:
   -> Drop en during slot 2: next cycle an=4'hF, seg=8'hFF, dec_code=0. Re-raise en: frame_start the next cycle, idx=0.
   -> Assert rst during slot 3 SHOW: next cycle an=4'hF, idx=0.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed seven-segment scan controller sharing one external hex decoder.
// Ports: clk/rst (sync, active-high); en enables scanning; digits_in/dp_in/blank_lz are
// snapshotted per frame; dec_code feeds the decoder, seg_in returns its active-low pattern;
// seg/an drive the pins (active-low); frame_start pulses on the first cycle of each frame.
module disp_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000,
    parameter int BLANK_CYC  = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [3:0]              dec_code,
    input  logic [7:0]              seg_in,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    logic [CW-1:0]                cnt;
    logic [IW-1:0]                idx;
    logic                         run;
    logic [NUM_DIGITS-1:0][3:0]   snap_dig;
    logic [NUM_DIGITS-1:0]        snap_dp;
    logic                         snap_blz;
    logic [NUM_DIGITS-1:0]        lz;
    logic                         z;
    logic                         show;
    // run is en delayed by one cycle, so every output decodes from registered state
    // and the cycle after en rises is a frame start with cnt=idx=0.
    assign frame_start = run && cnt == '0 && idx == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            run      <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            snap_dig <= '0;
            snap_dp  <= '0;
            snap_blz <= 1'b0;
        end else begin
            run <= en;
            if (frame_start) begin
                snap_dig <= digits_in;
                snap_dp  <= dp_in;
                snap_blz <= blank_lz;
            end
            if (!en) begin
                cnt <= '0;
                idx <= '0;
            end else if (run) begin
                if (cnt == CW'(TICK_DIV - 1)) begin
                    cnt <= '0;
                    idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
    // Walk from the most significant digit down; a digit is blanked while every
    // digit above it (and itself) is zero. Digit 0 is never blanked.
    always_comb begin
        lz = '0;
        z  = snap_blz;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            z     = z && snap_dig[i] == 4'd0;
            lz[i] = z;
        end
    end
    assign show     = run && cnt >= CW'(BLANK_CYC) && !lz[idx];
    assign an       = show ? ~(NUM_DIGITS'(1) << idx) : '1;
    assign seg      = show ? {seg_in[7:1], ~snap_dp[idx]} : 8'hFF;
    assign dec_code = run ? snap_dig[idx] : 4'd0;
endmodule
